// File: rtl/led_mode_pkg.sv
// led_mode_pkg: mode encoding, default blink half-periods and mode-step helpers for led_mode_controller
package led_mode_pkg;
   typedef enum logic [1:0] {
      MODE_OFF  = 2'd0,
      MODE_ON   = 2'd1,
      MODE_SLOW = 2'd2,
      MODE_FAST = 2'd3
   } led_mode_t;
   localparam int DEFAULT_SLOW_HALF_PERIOD = 12_500_000;
   localparam int DEFAULT_FAST_HALF_PERIOD = 2_500_000;
   function automatic led_mode_t next_mode(input led_mode_t m);
      return led_mode_t'(m + 2'd1);
   endfunction
   function automatic logic is_blink(input led_mode_t m);
      return m == MODE_SLOW || m == MODE_FAST;
   endfunction
endpackage

// File: rtl/led_mode_controller_blink_timer.sv
// blink_timer: half-period counter that pulses tick on its last count and restarts from 0
module blink_timer #(
   parameter int W = 2
) (
   input  logic         clock,
   input  logic         reset,
   input  logic         clear,
   input  logic         enable,
   input  logic [W:0]   half_period,
   output logic         tick
);
   logic [W-1:0] count_q, count_d;
   always_comb begin
      tick    = enable && ({1'b0, count_q} == half_period - 1'b1);
      count_d = (clear || !enable || tick) ? '0 : count_q + 1'b1;
   end
   always_ff @(posedge clock or posedge reset)
      if (reset) count_q <= '0;
      else       count_q <= count_d;
endmodule

// File: rtl/led_mode_controller.sv
// led_mode_controller: press-driven off/on/slow/fast LED mode cycle; LED_MODE_PRESS_EDGE_EN accepts only rising press levels
module led_mode_controller
   import led_mode_pkg::*;
#(
   parameter int SLOW_HALF_PERIOD = DEFAULT_SLOW_HALF_PERIOD,
   parameter int FAST_HALF_PERIOD = DEFAULT_FAST_HALF_PERIOD
) (
   input  logic      clock,
   input  logic      reset,
   input  logic      press,
   output logic      led,
   output led_mode_t mode
);
   localparam int TW = $clog2(SLOW_HALF_PERIOD);
   localparam logic [TW:0] SLOW_HP = (TW+1)'(SLOW_HALF_PERIOD);
   localparam logic [TW:0] FAST_HP = (TW+1)'(FAST_HALF_PERIOD);
   led_mode_t   mode_q, mode_d;
   logic        led_q, led_d, accept, tick, blink_en;
   logic [TW:0] half_period;
`ifdef LED_MODE_PRESS_EDGE_EN
   logic press_prev_q, press_prev_d;
   always_comb begin
      press_prev_d = press;
      accept       = press && !press_prev_q;
   end
   always_ff @(posedge clock or posedge reset)
      if (reset) press_prev_q <= 1'b0;
      else       press_prev_q <= press_prev_d;
`else
   always_comb accept = press;
`endif
   // a press on the wrap cycle wins: entry forces led high and drops the toggle
   always_comb begin
      mode_d      = accept ? next_mode(mode_q) : mode_q;
      led_d       = accept ? (mode_d != MODE_OFF) : (tick ? !led_q : led_q);
      blink_en    = is_blink(mode_q);
      half_period = mode_q == MODE_FAST ? FAST_HP : SLOW_HP;
   end
   always_ff @(posedge clock or posedge reset)
      if (reset) begin
         mode_q <= MODE_OFF;
         led_q  <= 1'b0;
      end else begin
         mode_q <= mode_d;
         led_q  <= led_d;
      end
   blink_timer #(.W(TW)) u_timer (
      .clock       (clock),
      .reset       (reset),
      .clear       (accept),
      .enable      (blink_en),
      .half_period (half_period),
      .tick        (tick)
   );
   assign led  = led_q;
   assign mode = mode_q;
endmodule

// File: tb/tb_led_mode_controller.sv
// tb_led_mode_controller: directed and random press sequences checked against a cycles-since-entry LED model
module tb_led_mode_controller;
   import led_mode_pkg::*;
   localparam int SLOW = 4;
   localparam int FAST = 2;
   localparam int SLOW_PAT[10] = '{1, 1, 1, 0, 0, 0, 0, 1, 1, 1};
   localparam int FAST_PAT[4]  = '{0, 1, 1, 0};
   logic      clock = 1'b0;
   logic      reset = 1'b1;
   logic      press = 1'b0;
   logic      led;
   led_mode_t mode;
   int total = 0;
   int passed = 0;
   int fails = 0;
   int m_mode = 0;
   int m_since = 0;
   bit m_prev = 1'b0;

   led_mode_controller #(.SLOW_HALF_PERIOD(SLOW), .FAST_HALF_PERIOD(FAST)) dut (
      .clock (clock),
      .reset (reset),
      .press (press),
      .led   (led),
      .mode  (mode)
   );

   always #5 clock = ~clock;

   function automatic int exp_led();
      if (m_mode == 0) return 0;
      if (m_mode == 1) return 1;
      return ((m_since / (m_mode == 2 ? SLOW : FAST)) % 2 == 0) ? 1 : 0;
   endfunction

   task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
      total++;
      assert (obs === exp) passed++;
      else begin
         fails++;
         $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic step(input logic p, input string tag);
      bit acc;
      press = p;
      @(posedge clock);
`ifdef LED_MODE_PRESS_EDGE_EN
      acc = p && !m_prev;
`else
      acc = p;
`endif
      m_prev = p;
      if (acc) begin
         m_mode  = (m_mode + 1) % 4;
         m_since = 0;
      end else m_since++;
      #1;
      chk({tag, "_mode"}, {2'b0, mode}, 4'(m_mode));
      chk({tag, "_led"}, {3'b0, led}, 4'(exp_led()));
   endtask

   task automatic async_reset(input string tag);
      #2 reset = 1'b1;
      #1;
      chk({tag, "_mode"}, {2'b0, mode}, 4'd0);
      chk({tag, "_led"}, {3'b0, led}, 4'd0);
      press = 1'b0;
      @(posedge clock);
      #1 reset = 1'b0;
      m_mode  = 0;
      m_since = 0;
      m_prev  = 1'b0;
   endtask

   initial begin
      repeat (2) @(posedge clock);
      #1;
      chk("reset_mode", {2'b0, mode}, 4'd0);
      chk("reset_led", {3'b0, led}, 4'd0);
      reset = 1'b0;
      repeat (10) step(1'b0, "idle");
      async_reset("reset_async");
      repeat (10) step(1'b0, "idle_after");
      for (int i = 0; i < 4; i++) begin
         step(1'b1, "walk_press");
         chk("walk_mode", {2'b0, mode}, 4'((i + 1) % 4));
         chk("walk_led", {3'b0, led}, 4'(i == 3 ? 0 : 1));
         repeat (19) step(1'b0, "walk_idle");
      end
      step(1'b1, "slow_on");
      step(1'b0, "slow_gap");
      step(1'b1, "slow_enter");
      chk("slow_entry_mode", {2'b0, mode}, 4'd2);
      chk("slow_entry_led", {3'b0, led}, 4'd1);
      for (int i = 0; i < 10; i++) begin
         step(1'b0, "slow");
         chk("slow_pat", {3'b0, led}, 4'(SLOW_PAT[i]));
      end
      for (int i = 0; i < 8 && (m_since % SLOW) != SLOW - 1; i++) step(1'b0, "to_wrap");
      step(1'b1, "collide");
      chk("collide_mode", {2'b0, mode}, 4'd3);
      chk("collide_led", {3'b0, led}, 4'd1);
      step(1'b0, "collide_hold");
      chk("collide_hold_led", {3'b0, led}, 4'd1);
      step(1'b0, "collide_toggle");
      chk("collide_toggle_led", {3'b0, led}, 4'd0);
      for (int i = 0; i < 4; i++) begin
         step(1'b0, "fast");
         chk("fast_pat", {3'b0, led}, 4'(FAST_PAT[i]));
      end
      step(1'b1, "to_off");
      step(1'b0, "off_idle");
      chk("off_mode", {2'b0, mode}, 4'd0);
      repeat (3) step(1'b1, "held");
`ifdef LED_MODE_PRESS_EDGE_EN
      chk("held_result", {2'b0, mode}, 4'd1);
`else
      chk("held_result", {2'b0, mode}, 4'd3);
`endif
      step(1'b0, "held_release");
      for (int i = 0; i < 8 && m_mode != 3; i++) begin
         step(1'b1, "reach_fast");
         step(1'b0, "reach_fast_gap");
      end
      for (int i = 0; i < 8 && exp_led() != 0; i++) step(1'b0, "fast_wait_low");
      chk("pre_reset_mode", {2'b0, mode}, 4'd3);
      chk("pre_reset_led", {3'b0, led}, 4'd0);
      async_reset("reset_fast");
      step(1'b1, "after_reset");
      chk("after_reset_mode", {2'b0, mode}, 4'd1);
      chk("after_reset_led", {3'b0, led}, 4'd1);
      step(1'b0, "after_reset_idle");
      for (int i = 0; i < 1500; i++) begin
         if ($urandom_range(0, 249) == 0) async_reset("rand_reset");
         step($urandom_range(0, 5) == 0, "rand");
      end
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
